// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed N-digit 7-segment driver with guard time, frame-synchronous update and LZ suppression
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_value           nibble k drives digit k (digit 0 least significant)
//   i_load, i_dp_in   one-cycle capture strobe and per-digit decimal points
//   i_blank           forces all outputs inactive (scanning continues)
//   i_lz_suppress     enables leading-zero suppression
//   o_seg_out         segments {g,f,e,d,c,b,a}, polarity SEG_ACTIVE_HIGH
//   o_dp_out          decimal point of the active digit, polarity SEG_ACTIVE_HIGH
//   o_dig_en          digit enables, one-hot when active, polarity DIG_ACTIVE_HIGH
//   o_frame_done      one-cycle pulse aligned with the end of the last digit slot
module seg7_mux_driver #(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 50000,
    parameter int GUARD           = 2,
    parameter int HEX_MODE        = 1,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int DIG_ACTIVE_HIGH = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic                      i_load,
    input  logic [NUM_DIGITS-1:0]     i_dp_in,
    input  logic                      i_blank,
    input  logic                      i_lz_suppress,
    output logic [6:0]                o_seg_out,
    output logic                      o_dp_out,
    output logic [NUM_DIGITS-1:0]     o_dig_en,
    output logic                      o_frame_done
);
    localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    // Inactive levels; XOR with these converts internal active-high values to pin polarity.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_HIGH != 0 ? 7'h00 : 7'h7f;
    localparam logic                  DP_OFF  = SEG_ACTIVE_HIGH == 0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_HIGH != 0 ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};
    // Glyphs F..0, entry n at bits [7n+6:7n].
    localparam logic [111:0] SEG_LUT = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    logic [SW-1:0]           r_slot;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend, r_disp;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic                    r_pend_valid;
    logic                    w_tc, w_boundary, w_active, w_supp;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_zero, w_onehot;

    // w_zero[k]: every nibble from k upward is zero
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
        assign w_zero[k] = r_disp[4*NUM_DIGITS-1:4*k] == '0;
    end

    assign w_tc       = r_slot == SW'(REFRESH_DIV - 1);
    assign w_boundary = w_tc && r_idx == IW'(NUM_DIGITS - 1);
    assign w_active   = !i_blank && r_slot >= SW'(GUARD);
    assign w_nib      = r_disp[r_idx*4 +: 4];
    assign w_supp     = i_lz_suppress && r_idx != '0 && w_zero[r_idx];
    assign w_seg      = (w_supp || (HEX_MODE == 0 && w_nib > 4'd9)) ? 7'h00 : SEG_LUT[w_nib*7 +: 7];
    assign w_onehot   = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else begin
            r_slot <= w_tc ? '0 : r_slot + 1'b1;
            if (w_tc)
                r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
        end
    end

    // A load on the boundary cycle bypasses pending and lands in the new frame directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_disp       <= '0;
            r_disp_dp    <= '0;
        end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
            if (i_load) begin
                r_disp    <= i_value;
                r_disp_dp <= i_dp_in;
            end else if (r_pend_valid) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
        end else if (i_load) begin
            r_pend       <= i_value;
            r_pend_dp    <= i_dp_in;
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg_out    <= SEG_OFF;
            o_dp_out     <= DP_OFF;
            o_dig_en     <= DIG_OFF;
            o_frame_done <= 1'b0;
        end else begin
            o_seg_out    <= w_active ? w_seg ^ SEG_OFF : SEG_OFF;
            o_dp_out     <= w_active ? r_disp_dp[r_idx] ^ DP_OFF : DP_OFF;
            o_dig_en     <= w_active ? w_onehot ^ DIG_OFF : DIG_OFF;
            o_frame_done <= w_boundary;
        end
    end
endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: scoreboard bench for seg7_mux_driver (hex and non-hex instances share stimulus)
module tb_seg7_mux_driver;
    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = ND * DIV;

    typedef struct {
        logic [6:0] seg;
        logic [6:0] seg_nohex;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank = 1'b0;
    logic        lz = 1'b0;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, fd_a, fd_b;
    logic [3:0]  dig_a, dig_b;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          cur_lz = 1'b0;

    int          t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_pv;

    logic [6:0]  glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD(GRD), .HEX_MODE(1),
                      .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_HIGH(0)) dut_hex (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .i_dp_in(dp_in),
        .i_blank(blank), .i_lz_suppress(lz), .o_seg_out(seg_a), .o_dp_out(dp_a),
        .o_dig_en(dig_a), .o_frame_done(fd_a));

    seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD(GRD), .HEX_MODE(0),
                      .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_HIGH(0)) dut_dec (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .i_dp_in(dp_in),
        .i_blank(blank), .i_lz_suppress(lz), .o_seg_out(seg_b), .o_dp_out(dp_b),
        .o_dig_en(dig_b), .o_frame_done(fd_b));

    function automatic logic [6:0] decode(input int n, input bit hex);
        return (n > 9 && !hex) ? 7'h00 : glyph[n];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Applies inputs at the falling edge and predicts the outputs registered at the next rising edge.
    task automatic drive(input bit rv, input bit ld, input logic [15:0] v,
                         input logic [3:0] dp, input bit blk, input bit lzv);
        exp_t e;
        int slot, idx, nib;
        bit act, supp, bnd;
        @(negedge clk);
        rst_n = rv; load = ld; value = v; dp_in = dp; blank = blk; lz = lzv;
        if (!rv) begin
            e = '{seg: 7'h00, seg_nohex: 7'h00, dp: 1'b0, dig: 4'hF, fd: 1'b0};
            t = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_pv = 1'b0;
        end else begin
            slot = t % DIV;
            idx  = (t / DIV) % ND;
            act  = slot >= GRD && !blk;
            nib  = int'((m_disp >> (4 * idx)) & 16'hF);
            supp = lzv && idx != 0 && (m_disp >> (4 * idx)) == 16'h0;
            e.seg       = act ? (supp ? 7'h00 : decode(nib, 1'b1)) : 7'h00;
            e.seg_nohex = act ? (supp ? 7'h00 : decode(nib, 1'b0)) : 7'h00;
            e.dp        = act && m_disp_dp[idx];
            e.dig       = act ? ~(4'b0001 << idx) : 4'hF;
            bnd         = (t % FRAME) == FRAME - 1;
            e.fd        = bnd;
            if (bnd && ld) begin
                m_disp = v; m_disp_dp = dp; m_pv = 1'b0;
            end else if (bnd && m_pv) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0;
            end else if (ld) begin
                m_pend = v; m_pend_dp = dp; m_pv = 1'b1;
            end
            t++;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, value, dp_in, 1'b0, cur_lz);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i <= FRAME && (t % FRAME) != phase; i++) idle(1);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        drive(1'b1, 1'b1, v, dp, 1'b0, cur_lz);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("seg_out", 32'(seg_a), 32'(mon_e.seg));
            chk("seg_out_nohex", 32'(seg_b), 32'(mon_e.seg_nohex));
            chk("dp_out", 32'(dp_a), 32'(mon_e.dp));
            chk("dig_en", 32'(dig_a), 32'(mon_e.dig));
            chk("frame_done", 32'(fd_a), 32'(mon_e.fd));
            chk("frame_done_nohex", 32'(fd_b), 32'(mon_e.fd));
        end
    end

    initial begin
        t = 0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        idle(2 * FRAME + 4);
        load_val(16'hA5C9, 4'b0100);
        idle(2 * FRAME);
        run_to(10);
        load_val(16'h1234, 4'b0001);
        run_to(18);
        load_val(16'h5678, 4'b0010);
        idle(2 * FRAME);
        cur_lz = 1'b1;
        load_val(16'h0050, 4'b1000);
        idle(2 * FRAME);
        load_val(16'h0000, 4'b0000);
        idle(2 * FRAME);
        cur_lz = 1'b0;
        run_to(FRAME - 1);
        load_val(16'h9876, 4'b0011);
        idle(FRAME);
        run_to(12);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, value, dp_in, 1'b1, cur_lz);
        idle(FRAME);
        run_to(12);
        load_val(16'hBEEF, 4'b1111);
        run_to(20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg_a), 32'h0);
        chk("async_rst_dig", 32'(dig_a), 32'hF);
        chk("async_rst_dp", 32'(dp_a), 32'h0);
        chk("async_rst_fd", 32'(fd_a), 32'h0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, value, dp_in, 1'b0, 1'b0);
        idle(2 * FRAME);
        for (int i = 0; i < 900; i++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            drive(1'b1, $urandom_range(0, 9) == 0, v, 4'($urandom), $urandom_range(0, 7) == 0,
                  1'($urandom));
        end
        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Time-multiplexed driver for an N-digit common-segment 7-segment display.
- Successor to the team's single-digit combinational BCD-to-7-segment decoder; adds:
  - a parametrised digit count;
  - full hex decode;
  - a refresh scanner with anti-ghosting guard time;
  - tear-free frame-synchronous value update;
  - leading-zero suppression, decimal points and output polarity selection.
- Sits between the datapath (binary/BCD word) and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits; range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ GUARD+2.
- GUARD, 2: cycles at the start of each slot with all digits disabled.
- HEX_MODE, 1: 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 show blank.
- SEG_ACTIVE_HIGH, 1: polarity of seg_out and dp_out.
- DIG_ACTIVE_HIGH, 0: polarity of dig_en.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- value, input, 4*NUM_DIGITS: nibble k drives digit k; digit 0 is least significant.
- load, input, 1: one-cycle strobe; captures value and dp_in.
- dp_in, input, NUM_DIGITS: decimal point per digit.
- blank, input, 1: forces the display dark.
- lz_suppress, input, 1: enables leading-zero suppression.
- seg_out, output, 7: segments {g,f,e,d,c,b,a}; bit 0 = a.
- dp_out, output, 1: decimal point of the active digit.
- dig_en, output, NUM_DIGITS: digit enables; one-hot when active.
- frame_done, output, 1: one-cycle pulse at the end of the last digit slot.

Behaviour:
- Reset (async, rst_n=0):
  - slot counter = 0, digit index = 0;
  - pending and display registers = 0, pending_valid = 0;
  - seg_out, dp_out and dig_en = inactive level per polarity;
  - frame_done = 0.
  - Reset mid-frame drops straight to these values; after release, scanning restarts at digit 0, slot count 0.
- Slot counter:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and the digit index increments modulo NUM_DIGITS.
  - Digit index NUM_DIGITS-1 wraps to 0; this is the frame boundary.
- Update path:
  - load=1 captures value and dp_in into pending and sets pending_valid.
  - At the frame boundary, if pending_valid: display <= pending, pending_valid cleared.
  - load coincident with the boundary cycle: the new value goes directly to display for the new frame; pending_valid ends 0.
  - Multiple loads within a frame: last one wins.
  - The display register never changes mid-frame.
- Decode (internal, active-high):

      0:0111111  1:0000110  2:1011011  3:1001111
      4:1100110  5:1101101  6:1111101  7:0000111
      8:1111111  9:1101111  A:1110111  b:1111100
      C:0111001  d:1011110  E:1111001  F:1110001

  - With HEX_MODE=0, nibbles 10..15 decode to 0000000.
- Leading-zero suppression (lz_suppress=1):
  - Digit k is suppressed when all nibbles k..NUM_DIGITS-1 are 0 and k≠0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows segments 0000000; its decimal point is still shown.
- Guard time:
  - While slot count < GUARD, dig_en is fully inactive and segments are inactive.
  - Otherwise dig_en is one-hot at the current digit index.
- Outputs:
  - Registered; they reflect the counter/index state of the previous cycle (1-cycle latency).
  - When SEG_ACTIVE_HIGH=0, seg_out and dp_out are inverted.
  - When DIG_ACTIVE_HIGH=0, dig_en is inverted.
- blank=1:
  - All outputs go inactive on the next cycle.
  - The counters and update path keep running.
  - Release resumes mid-slot with no resync.
- frame_done:
  - Asserts in the cycle after the terminal count of the slot for digit NUM_DIGITS-1 (aligned with the registered outputs).
  - Pulses in every frame regardless of blank.
- NUM_DIGITS=1: the index stays 0 and every slot end is a frame boundary.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, SEG_ACTIVE_HIGH=1, DIG_ACTIVE_HIGH=0.

1. Reset scan: release rst_n.
   - dig_en=1111 for 2 cycles of each slot, then 1110, 1101, 1011, 0111 in 8-cycle slots.
   - seg_out shows 0111111 (digit 0) when enabled.
   - frame_done pulses every 32 cycles.
2. Hex decode: load value=16'hA5C9, dp_in=0100.
   - Next frame shows digit0 = 1101111, digit1 = 0111001, digit2 = 1101101 with dp_out=1, digit3 = 1110111.
   - Repeat with HEX_MODE=0: digits 1 and 3 show 0000000.
3. Tear-free update: load 16'h1234 in slot of digit 1, then 16'h5678 in slot of digit 2.
   - Remainder of that frame still shows the old value.
   - Next frame shows 5678 only; 1234 is never displayed.
4. Leading zeros: value=16'h0050, lz_suppress=1.
   - Digits 3 and 2 show 0000000; digit 1 shows 1101101; digit 0 shows 0111111.
   - Value 16'h0000 shows only digit 0 as 0111111.
5. Boundary and blank:
   - load asserted exactly on the frame-boundary cycle: the new value appears in the immediately starting frame.
   - blank=1 mid-slot: seg_out=0000000 and dig_en=1111 next cycle, frame_done cadence unchanged.
6. Async reset mid-frame:
   - Assert rst_n low during the digit-2 slot: outputs go inactive immediately without a clock edge.
   - After release, scanning restarts at digit 0 with a pending load discarded.
